// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg: shared constants for the data-side memory subsystem
package dmem_bus_pkg;
  localparam logic [11:0] OFF_MTIME_LO = 12'h000;
  localparam logic [11:0] OFF_MTIME_HI = 12'h004;
  localparam logic [11:0] OFF_CMP_LO   = 12'h008;
  localparam logic [11:0] OFF_CMP_HI   = 12'h00C;
  localparam logic [11:0] OFF_CTRL     = 12'h010;
  localparam logic [11:0] OFF_GPIO_OUT = 12'h020;
  localparam logic [11:0] OFF_GPIO_IN  = 12'h024;
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;
  function automatic int ram_aw(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: 64-bit machine timer with prescaler, compare register and level irq
module dmem_timer
  import dmem_bus_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_we,
  input  logic [11:0] i_off,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_en,
  output logic        o_irq
);
  logic [31:0] r_pre;
  logic [63:0] r_mtime, r_cmp;
  logic        r_en, r_irq;
  logic        w_tick, w_en_n, w_pre_clr;
  logic [63:0] w_mtime_n, w_cmp_n;
  always_comb begin
    w_tick    = r_en && r_pre == 32'(PRESCALE - 1);
    w_mtime_n = r_mtime + {63'd0, w_tick};
    // a software write replaces the whole increment; the other half holds
    w_mtime_n = (i_we && i_off == OFF_MTIME_LO) ? {r_mtime[63:32], i_wdata} :
                (i_we && i_off == OFF_MTIME_HI) ? {i_wdata, r_mtime[31:0]} : w_mtime_n;
    w_cmp_n   = (i_we && i_off == OFF_CMP_LO) ? {r_cmp[63:32], i_wdata} :
                (i_we && i_off == OFF_CMP_HI) ? {i_wdata, r_cmp[31:0]} : r_cmp;
    w_en_n    = (i_we && i_off == OFF_CTRL) ? i_wdata[0] : r_en;
    w_pre_clr = w_tick || (i_we && i_off == OFF_CTRL && !i_wdata[0]);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre   <= '0;
      r_mtime <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_pre   <= w_pre_clr ? '0 : r_en ? r_pre + 32'd1 : r_pre;
      r_mtime <= w_mtime_n;
      r_cmp   <= w_cmp_n;
      r_en    <= w_en_n;
      r_irq   <= w_en_n && (w_mtime_n >= w_cmp_n);
    end
  end
  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_cmp;
  assign o_en       = r_en;
  assign o_irq      = r_irq;
endmodule

// File: rtl/dmem_bus.sv
// dmem_bus: data RAM plus memory-mapped timer and GPIO for the core's M stage
module dmem_bus
  import dmem_bus_pkg::*;
#(
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter int          PRESCALE    = 1,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [2:0]        size_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              timer_irq_o,
  output logic [GPIO_W-1:0] gpio_o,
  input  logic [GPIO_W-1:0] gpio_i
);
  localparam int AW = ram_aw(RAM_WORDS);
  logic [31:0]       r_mem [RAM_WORDS];
  logic [GPIO_W-1:0] r_gpio_out, r_s1, r_s2;
  logic              r_err;
  logic [11:0]       w_off;
  logic              w_ram, w_preg, w_per, w_legal, w_word, w_mis, w_ok, w_en, w_irq;
  logic [3:0]        w_be;
  logic [31:0]       w_wd, w_pval, w_rword, w_sh, w_ld;
  logic [63:0]       w_mtime, w_cmp;
  always_comb begin
    w_off   = addr_i[11:0];
    w_ram   = addr_i[31:AW+2] == '0;
    w_preg  = w_off == OFF_MTIME_LO || w_off == OFF_MTIME_HI || w_off == OFF_CMP_LO ||
              w_off == OFF_CMP_HI || w_off == OFF_CTRL || w_off == OFF_GPIO_OUT || w_off == OFF_GPIO_IN;
    w_per   = addr_i[31:12] == PERIPH_BASE[31:12] && w_preg;
    w_legal = size_i == SZ_B || size_i == SZ_H || size_i == SZ_W || size_i == SZ_BU || size_i == SZ_HU;
    w_word  = size_i == SZ_W;
    w_mis   = (size_i[1:0] == 2'b01 && addr_i[0]) || (w_word && addr_i[1:0] != 2'b00);
    // peripherals accept only aligned word accesses
    w_ok    = w_legal && !w_mis && (w_ram || (w_per && w_word));
    w_be    = size_i[1] ? 4'hF : size_i[0] ? 4'b0011 << addr_i[1:0] : 4'b0001 << addr_i[1:0];
    w_wd    = size_i[1] ? wdata_i : size_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    w_pval  = w_off == OFF_MTIME_LO ? w_mtime[31:0] :
              w_off == OFF_MTIME_HI ? w_mtime[63:32] :
              w_off == OFF_CMP_LO   ? w_cmp[31:0] :
              w_off == OFF_CMP_HI   ? w_cmp[63:32] :
              w_off == OFF_CTRL     ? {30'd0, w_irq, w_en} :
              w_off == OFF_GPIO_OUT ? 32'(r_gpio_out) :
              w_off == OFF_GPIO_IN  ? 32'(r_s2) : 32'd0;
    w_rword = w_ram ? r_mem[addr_i[AW+1:2]] : w_pval;
    w_sh    = w_rword >> {addr_i[1:0], 3'b000};
    w_ld    = size_i[1] ? w_sh :
              size_i[0] ? {{16{!size_i[2] && w_sh[15]}}, w_sh[15:0]} :
                          {{24{!size_i[2] && w_sh[7]}}, w_sh[7:0]};
    rdata_o = w_ok ? w_ld : 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (we_i && w_ok && w_ram)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[addr_i[AW+1:2]][8*b +: 8] <= w_wd[8*b +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err      <= 1'b0;
      r_gpio_out <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      r_err      <= (we_i || re_i) && !w_ok;
      r_gpio_out <= (we_i && w_ok && w_per && w_off == OFF_GPIO_OUT) ? wdata_i[GPIO_W-1:0] : r_gpio_out;
      r_s1       <= gpio_i;
      r_s2       <= r_s1;
    end
  end
  dmem_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_we      (we_i && w_ok && w_per),
    .i_off     (w_off),
    .i_wdata   (wdata_i),
    .o_mtime   (w_mtime),
    .o_mtimecmp(w_cmp),
    .o_en      (w_en),
    .o_irq     (w_irq)
  );
  assign err_o       = r_err;
  assign timer_irq_o = w_irq;
  assign gpio_o      = r_gpio_out;
endmodule
